// File: rtl/branch_predictor_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | branch_predictor_pkg : shared encodings and defaults for the BPU     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package branch_predictor_pkg;

   // 2-bit saturating counter states; bit[1] is the predicted direction
   typedef enum logic [1:0] {
      SNT = 2'b00,
      WNT = 2'b01,
      WT  = 2'b10,
      ST  = 2'b11
   } cnt_e;

   localparam int C_IDX_W_DEF = 6;
   localparam int C_GHR_W_DEF = 6;

   // Primary opcodes of the conditional branches that train the table
   localparam logic [5:0] C_OP_REGIMM = 6'b000001;
   localparam logic [5:0] C_OP_BEQ    = 6'b000100;
   localparam logic [5:0] C_OP_BNE    = 6'b000101;

   function automatic logic cnt_predicts_taken(input logic [1:0] cnt);
      return cnt[1];
   endfunction

endpackage
`default_nettype wire

// File: rtl/branch_predictor_sat_counter2.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sat_counter2 : next value of a 2-bit saturating counter              |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module sat_counter2
   import branch_predictor_pkg::*;
(
   input  logic [1:0] cur_i,
   input  logic       taken_i,
   output logic [1:0] nxt_o
);

   always_comb begin
      nxt_o = cur_i;
      if (taken_i) begin
         if (cur_i != ST) nxt_o = cur_i + 2'd1;
      end else begin
         if (cur_i != SNT) nxt_o = cur_i - 2'd1;
      end
   end

endmodule
`default_nettype wire

// File: rtl/branch_predictor.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | branch_predictor : direct-mapped 2-bit BHT with perf counters        |
// | Optional gshare indexing with macro BPU_GSHARE_EN. Revision: 1.0     |
// +----------------------------------------------------------------------+
module branch_predictor
   import branch_predictor_pkg::*;
#(
   parameter int         IDX_W    = C_IDX_W_DEF,
   parameter logic [1:0] CNT_INIT = WNT,
   parameter int         GHR_W    = C_GHR_W_DEF
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        fetch_en,
   input  logic [31:0] fetch_pc,
   output logic        pred_valid,
   output logic        pred_taken,
   input  logic        update_en,
   input  logic [31:0] update_pc,
   input  logic        update_taken,
   input  logic        update_pred,
   output logic [31:0] branch_cnt,
   output logic [31:0] mispred_cnt
);

   localparam int C_ENTRIES = 1 << IDX_W;

   logic [1:0]       bht_q [C_ENTRIES];
   logic [IDX_W-1:0] fetch_idx;
   logic [IDX_W-1:0] upd_idx;
   logic [1:0]       upd_cur;
   logic [1:0]       upd_nxt;
   logic             pred_valid_q, pred_valid_d;
   logic             pred_taken_q, pred_taken_d;
   logic [31:0]      branch_cnt_q, branch_cnt_d;
   logic [31:0]      mispred_cnt_q, mispred_cnt_d;

   logic unused_pc_bits;
   assign unused_pc_bits = ^{fetch_pc[31:IDX_W+2], fetch_pc[1:0],
                             update_pc[31:IDX_W+2], update_pc[1:0]};

`ifdef BPU_GSHARE_EN
   logic [GHR_W-1:0] ghr_q, ghr_d;

   // Update side hashes with the history as it stood before this cycle's shift
   assign fetch_idx = fetch_pc[IDX_W+1:2] ^ IDX_W'(ghr_q);
   assign upd_idx   = update_pc[IDX_W+1:2] ^ IDX_W'(ghr_q);
   assign ghr_d     = update_en ? GHR_W'({ghr_q, update_taken}) : ghr_q;

   always_ff @(posedge clk) begin
      if (!resetn) ghr_q <= '0;
      else         ghr_q <= ghr_d;
   end
`else
   assign fetch_idx = fetch_pc[IDX_W+1:2];
   assign upd_idx   = update_pc[IDX_W+1:2];
`endif

   assign upd_cur = bht_q[upd_idx];

   sat_counter2 u_sat (
      .cur_i   (upd_cur),
      .taken_i (update_taken),
      .nxt_o   (upd_nxt)
   );

   // Prediction reads the table before this edge's update lands (no bypass)
   always_comb begin
      pred_valid_d  = pred_valid_q;
      pred_taken_d  = pred_taken_q;
      branch_cnt_d  = branch_cnt_q;
      mispred_cnt_d = mispred_cnt_q;
      if (fetch_en) begin
         pred_valid_d = 1'b1;
         pred_taken_d = cnt_predicts_taken(bht_q[fetch_idx]);
      end
      if (update_en) begin
         if (branch_cnt_q != 32'hFFFF_FFFF) branch_cnt_d = branch_cnt_q + 32'd1;
         if ((update_taken != update_pred) && (mispred_cnt_q != 32'hFFFF_FFFF))
            mispred_cnt_d = mispred_cnt_q + 32'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         for (int i = 0; i < C_ENTRIES; i++) bht_q[i] <= CNT_INIT;
      end else if (update_en) begin
         bht_q[upd_idx] <= upd_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         pred_valid_q  <= 1'b0;
         pred_taken_q  <= 1'b0;
         branch_cnt_q  <= '0;
         mispred_cnt_q <= '0;
      end else begin
         pred_valid_q  <= pred_valid_d;
         pred_taken_q  <= pred_taken_d;
         branch_cnt_q  <= branch_cnt_d;
         mispred_cnt_q <= mispred_cnt_d;
      end
   end

   assign pred_valid  = pred_valid_q;
   assign pred_taken  = pred_taken_q;
   assign branch_cnt  = branch_cnt_q;
   assign mispred_cnt = mispred_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_branch_predictor.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_branch_predictor : scoreboard bench for branch_predictor          |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_branch_predictor;

   logic        clk;
   logic        resetn;
   logic        fetch_en;
   logic [31:0] fetch_pc;
   logic        pred_valid;
   logic        pred_taken;
   logic        update_en;
   logic [31:0] update_pc;
   logic        update_taken;
   logic        update_pred;
   logic [31:0] branch_cnt;
   logic [31:0] mispred_cnt;

   int checks   = 0;
   int failures = 0;
   bit exp_q[$];
   bit mon_fire;
   bit mon_exp;

   branch_predictor dut (
      .clk          (clk),
      .resetn       (resetn),
      .fetch_en     (fetch_en),
      .fetch_pc     (fetch_pc),
      .pred_valid   (pred_valid),
      .pred_taken   (pred_taken),
      .update_en    (update_en),
      .update_pc    (update_pc),
      .update_taken (update_taken),
      .update_pred  (update_pred),
      .branch_cnt   (branch_cnt),
      .mispred_cnt  (mispred_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Monitor: every accepted fetch produces one prediction on the next cycle
   always @(posedge clk) begin
      mon_fire = fetch_en && resetn;
      #1;
      if (mon_fire) begin
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL pred_unexpected actual=%b required=none", pred_taken);
         end else begin
            mon_exp = exp_q.pop_front();
            if (pred_valid !== 1'b1 || pred_taken !== mon_exp) begin
               failures++;
               $display("FAIL pred actual=valid%b/taken%b required=valid1/taken%b",
                        pred_valid, pred_taken, mon_exp);
            end
         end
      end
   end

   task automatic do_reset();
      resetn = 1'b0;
      @(negedge clk);
      @(negedge clk);
      resetn = 1'b1;
   endtask

   task automatic fetch(input logic [31:0] pc, input bit exp);
      fetch_en = 1'b1;
      fetch_pc = pc;
      exp_q.push_back(exp);
      @(negedge clk);
      fetch_en = 1'b0;
   endtask

   task automatic update(input logic [31:0] pc, input bit taken, input bit pred);
      update_en    = 1'b1;
      update_pc    = pc;
      update_taken = taken;
      update_pred  = pred;
      @(negedge clk);
      update_en = 1'b0;
   endtask

   initial begin
      resetn = 1'b0; fetch_en = 1'b0; fetch_pc = '0;
      update_en = 1'b0; update_pc = '0; update_taken = 1'b0; update_pred = 1'b0;
      @(negedge clk);
      do_reset();
      chk("rst_pred_valid", {31'd0, pred_valid}, 32'd0);
      chk("rst_pred_taken", {31'd0, pred_taken}, 32'd0);
      chk("rst_branch_cnt", branch_cnt, 32'd0);
      chk("rst_mispred_cnt", mispred_cnt, 32'd0);

      // Training at index 4: 01 -> 10 -> 11 -> 11 -> 10
      fetch(32'h0040_0010, 1'b0);
      update(32'h0040_0010, 1'b1, 1'b0);
      update(32'h0040_0010, 1'b1, 1'b0);
      fetch(32'h0040_0010, 1'b1);
      update(32'h0040_0010, 1'b1, 1'b1);
      fetch(32'h0040_0010, 1'b1);
      update(32'h0040_0010, 1'b0, 1'b1);
      fetch(32'h0040_0010, 1'b1);

      // Same-cycle read/write at index 16: old value predicts, update lands
      fetch_en = 1'b1; fetch_pc = 32'h40; exp_q.push_back(1'b0);
      update_en = 1'b1; update_pc = 32'h40; update_taken = 1'b1; update_pred = 1'b0;
      @(negedge clk);
      fetch_en = 1'b0; update_en = 1'b0;
      fetch(32'h40, 1'b1);

      // Stall: outputs hold while the PC wanders
      for (int i = 0; i < 3; i++) begin
         fetch_pc = 32'h80 + 32'(i * 4);
         @(negedge clk);
         chk("stall_valid", {31'd0, pred_valid}, 32'd1);
         chk("stall_taken", {31'd0, pred_taken}, 32'd1);
      end
      fetch(32'h80, 1'b0);

      // Aliasing: 0x4 and 0x104 share index 1
      fetch(32'h104, 1'b0);
      update(32'h4, 1'b1, 1'b0);
      fetch(32'h104, 1'b1);

      // Mid-operation reset clears the table and the held prediction
      do_reset();
      chk("rst2_pred_valid", {31'd0, pred_valid}, 32'd0);
      chk("rst2_branch_cnt", branch_cnt, 32'd0);
      fetch(32'h0040_0010, 1'b0);

      update(32'h100, 1'b1, 1'b1);
      update(32'h100, 1'b0, 1'b1);
      update(32'h200, 1'b0, 1'b0);
      update(32'h200, 1'b1, 1'b0);
      update(32'h300, 1'b1, 1'b1);
      chk("branch_cnt_5", branch_cnt, 32'd5);
      chk("mispred_cnt_2", mispred_cnt, 32'd2);
      @(negedge clk);
      chk("idle_branch_cnt", branch_cnt, 32'd5);
      chk("idle_mispred_cnt", mispred_cnt, 32'd2);

      force dut.branch_cnt_q = 32'hFFFF_FFFF;
      #1;
      release dut.branch_cnt_q;
      update(32'h300, 1'b1, 1'b1);
      chk("branch_cnt_sat", branch_cnt, 32'hFFFF_FFFF);
      chk("mispred_after_sat", mispred_cnt, 32'd2);

      @(negedge clk);
      chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
